scan_chain_capture_ip2: RTL and testbench



---
 rtl/scan_chain_capture_ip2_pkg.sv | 21 ++
 rtl/scan_chain_capture_ip2_if.sv | 14 +
 rtl/scan_chain_capture_ip2_word_mux.sv | 55 +++++
 rtl/scan_chain_capture_ip2.sv | 107 ++++++++++
 tb/tb_scan_chain_capture_ip2.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_chain_capture_ip2_pkg.sv
// Shared types and constants for the IP2 scan-chain capture path.
package scan_chain_capture_ip2_pkg;

    localparam int scan_reg_bits_total            = 768;
    localparam int scan_rd_words                  = scan_reg_bits_total / 32;
    localparam int status_index_scan_cap_done     = 18;
    localparam int status_index_scan_cap_overflow = 19;

    typedef enum logic [1:0] {
        IDLE_CAP_IP2    = 2'd0,
        SKIP_CAP_IP2    = 2'd1,
        CAPTURE_CAP_IP2 = 2'd2,
        DONE_CAP_IP2    = 2'd3
    } state_t_cap_ip2;

    // A strobe only counts while the sequencer is actually shifting.
    function automatic logic qualified_stb(input logic stb, input logic en);
        return stb & en;
    endfunction

endpackage

// File: rtl/scan_chain_capture_ip2_if.sv
// Register read-path bus between the command handler and the capture block.
interface scan_chain_capture_ip2_if #(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 32
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [WORD_W-1:0] rd_data;
    logic              rd_err;

    modport master (output rd_req, rd_addr, input  rd_ack, rd_data, rd_err);
    modport slave  (input  rd_req, rd_addr, output rd_ack, rd_data, rd_err);
endinterface

// File: rtl/scan_chain_capture_ip2_word_mux.sv
// Registered word selector over the captured scan chain with address-range check.
module scan_chain_capture_ip2_word_mux #(
    parameter int SCAN_BITS = 768,
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic [SCAN_BITS-1:0] storage,
    input  logic                 busy,
    output logic                 rd_ack,
    output logic [WORD_W-1:0]    rd_data,
    output logic                 rd_err
);
    localparam int N_WORDS = SCAN_BITS / WORD_W;

    logic [WORD_W-1:0] words_s [N_WORDS];
    logic              addr_ok_s;
    logic [WORD_W-1:0] sel_word_s;

    for (genvar k = 0; k < N_WORDS; k++) begin : g_words
        assign words_s[k] = storage[k*WORD_W +: WORD_W];
    end

    assign addr_ok_s = (rd_addr < ADDR_W'(N_WORDS));

    // Pick the addressed word; out-of-range addresses read as zero.
    always_comb begin
        sel_word_s = '0;
        if (addr_ok_s) begin
            sel_word_s = words_s[rd_addr];
        end else begin
            sel_word_s = '0;
        end
    end

    // One-cycle acknowledge carrying the word as it stood when requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
            rd_err  <= 1'b0;
        end else if (rd_req) begin
            rd_ack  <= 1'b1;
            rd_data <= sel_word_s;
            rd_err  <= ~addr_ok_s | busy;
        end else begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
            rd_err  <= 1'b0;
        end
    end
endmodule

// File: rtl/scan_chain_capture_ip2.sv
// Captures the IP2 scan_out stream during shift-in and serves it as 32-bit words.
module scan_chain_capture_ip2
    import scan_chain_capture_ip2_pkg::*;
#(
    parameter int SCAN_BITS = 768,
    parameter int WORD_W    = 32,
    parameter int SKIP_W    = 6,
    parameter int ADDR_W    = 5
) (
    input  logic                      fw_pl_clk1,
    input  logic                      fw_rst,
    input  logic                      cap_start,
    input  logic [SKIP_W-1:0]         cfg_skip,
    input  logic                      shift_en,
    input  logic                      sample_stb,
    input  logic                      scan_out,
    scan_chain_capture_ip2_if.slave   rd,
    output logic                      cap_busy,
    output logic                      cap_done,
    output logic                      cap_overflow,
    output logic [9:0]                bit_count
);
    localparam logic [9:0]        BITS_FULL = 10'(SCAN_BITS);
    localparam logic [9:0]        BITS_LAST = 10'(SCAN_BITS - 1);
    localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);

    state_t_cap_ip2       state_r;
    logic [SKIP_W-1:0]    skip_cnt_r;
    logic [SCAN_BITS-1:0] storage_r;
    logic [9:0]           bit_count_r;
    logic                 cap_overflow_r;
    logic                 stb_s;

    assign stb_s = qualified_stb(sample_stb, shift_en);

    // Capture sequencer: restart on cap_start, skip leading strobes, shift in bits, flag overrun.
    always_ff @(posedge fw_pl_clk1) begin
        if (fw_rst) begin
            state_r        <= IDLE_CAP_IP2;
            skip_cnt_r     <= '0;
            storage_r      <= '0;
            bit_count_r    <= 10'd0;
            cap_overflow_r <= 1'b0;
        end else if (cap_start) begin
            // Any strobe in this same cycle is deliberately dropped.
            storage_r      <= '0;
            bit_count_r    <= 10'd0;
            cap_overflow_r <= 1'b0;
            skip_cnt_r     <= cfg_skip;
            state_r        <= (cfg_skip != '0) ? SKIP_CAP_IP2 : CAPTURE_CAP_IP2;
        end else begin
            case (state_r)
                IDLE_CAP_IP2: begin
                    state_r <= IDLE_CAP_IP2;
                end
                SKIP_CAP_IP2: begin
                    if (stb_s) begin
                        skip_cnt_r <= skip_cnt_r - SKIP_ONE;
                        if (skip_cnt_r == SKIP_ONE) begin
                            state_r <= CAPTURE_CAP_IP2;
                        end
                    end
                end
                CAPTURE_CAP_IP2: begin
                    if (stb_s) begin
                        storage_r <= {storage_r[SCAN_BITS-2:0], scan_out};
                        if (bit_count_r != BITS_FULL) begin
                            bit_count_r <= bit_count_r + 10'd1;
                        end
                        if (bit_count_r == BITS_LAST) begin
                            state_r <= DONE_CAP_IP2;
                        end
                    end
                end
                DONE_CAP_IP2: begin
                    if (stb_s) begin
                        cap_overflow_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE_CAP_IP2;
                end
            endcase
        end
    end

    assign cap_busy     = (state_r == SKIP_CAP_IP2) || (state_r == CAPTURE_CAP_IP2);
    assign cap_done     = (state_r == DONE_CAP_IP2);
    assign cap_overflow = cap_overflow_r;
    assign bit_count    = bit_count_r;

    scan_chain_capture_ip2_word_mux #(
        .SCAN_BITS (SCAN_BITS),
        .WORD_W    (WORD_W),
        .ADDR_W    (ADDR_W)
    ) u_word_mux (
        .clk     (fw_pl_clk1),
        .rst     (fw_rst),
        .rd_req  (rd.rd_req),
        .rd_addr (rd.rd_addr),
        .storage (storage_r),
        .busy    (cap_busy),
        .rd_ack  (rd.rd_ack),
        .rd_data (rd.rd_data),
        .rd_err  (rd.rd_err)
    );
endmodule

// File: tb/tb_scan_chain_capture_ip2.sv
// Directed, table-driven bench for scan_chain_capture_ip2.
module tb_scan_chain_capture_ip2;

    logic       fw_pl_clk1 = 1'b0;
    logic       fw_rst     = 1'b1;
    logic       cap_start  = 1'b0;
    logic [5:0] cfg_skip   = 6'd0;
    logic       shift_en   = 1'b1;
    logic       sample_stb = 1'b0;
    logic       scan_out   = 1'b0;
    logic       cap_busy;
    logic       cap_done;
    logic       cap_overflow;
    logic [9:0] bit_count;

    scan_chain_capture_ip2_if #(.ADDR_W(5), .WORD_W(32)) rd_if ();

    scan_chain_capture_ip2 dut (
        .fw_pl_clk1   (fw_pl_clk1),
        .fw_rst       (fw_rst),
        .cap_start    (cap_start),
        .cfg_skip     (cfg_skip),
        .shift_en     (shift_en),
        .sample_stb   (sample_stb),
        .scan_out     (scan_out),
        .rd           (rd_if),
        .cap_busy     (cap_busy),
        .cap_done     (cap_done),
        .cap_overflow (cap_overflow),
        .bit_count    (bit_count)
    );

    always #5 fw_pl_clk1 = ~fw_pl_clk1;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } rd_vec_t;

    int           total = 0;
    int           bad   = 0;
    logic [767:0] pat;
    rd_vec_t      vec [6];
    logic [31:0]  d;
    logic         e;
    logic         k;
    logic [31:0]  acc;
    logic         eacc;

    task automatic tick();
        @(posedge fw_pl_clk1);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic v);
        scan_out   = v;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        scan_out   = 1'b0;
        tick();
    endtask

    task automatic start(input logic [5:0] s);
        cfg_skip  = s;
        cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] dd, output logic ee, output logic kk);
        rd_if.rd_req  = 1'b1;
        rd_if.rd_addr = a;
        tick();
        rd_if.rd_req = 1'b0;
        kk = rd_if.rd_ack;
        dd = rd_if.rd_data;
        ee = rd_if.rd_err;
    endtask

    task automatic read_all(output logic [31:0] or_data, output logic or_err);
        logic [31:0] rdd;
        logic        ree;
        logic        rkk;
        or_data = 32'd0;
        or_err  = 1'b0;
        for (int w = 0; w < 24; w++) begin
            do_read(5'(w), rdd, ree, rkk);
            or_data = or_data | rdd;
            or_err  = or_err | ree | ~rkk;
        end
    endtask

    initial begin
        rd_if.rd_req  = 1'b0;
        rd_if.rd_addr = 5'd0;
        for (int w = 0; w < 24; w++) begin
            logic [31:0] kw;
            kw = 32'(w);
            pat[w*32 +: 32] = 32'h0123_4567 + (32'h1020_4081 * kw);
        end
        vec[0] = '{5'd0,  pat[31:0],    1'b0};
        vec[1] = '{5'd5,  pat[191:160], 1'b0};
        vec[2] = '{5'd12, pat[415:384], 1'b0};
        vec[3] = '{5'd23, pat[767:736], 1'b0};
        vec[4] = '{5'd24, 32'd0,        1'b1};
        vec[5] = '{5'd31, 32'd0,        1'b1};

        // Reset state
        tick(); tick();
        fw_rst = 1'b0;
        chk("rst_busy", 32'(cap_busy), 32'd0);
        chk("rst_done", 32'(cap_done), 32'd0);
        chk("rst_ovf", 32'(cap_overflow), 32'd0);
        chk("rst_count", 32'(bit_count), 32'd0);
        chk("rst_ack", 32'(rd_if.rd_ack), 32'd0);

        // Reset mid-capture
        start(6'd0);
        chk("mid_busy", 32'(cap_busy), 32'd1);
        for (int i = 0; i < 100; i++) strobe(1'b1);
        chk("mid_count", 32'(bit_count), 32'd100);
        fw_rst = 1'b1;
        tick();
        fw_rst = 1'b0;
        chk("abort_count", 32'(bit_count), 32'd0);
        chk("abort_busy", 32'(cap_busy), 32'd0);
        chk("abort_done", 32'(cap_done), 32'd0);
        read_all(acc, eacc);
        chk("abort_words", acc, 32'd0);
        chk("idle_rd_err", 32'(eacc), 32'd0);

        // Full capture, MSB of pattern first
        start(6'd0);
        for (int i = 0; i < 768; i++) begin
            strobe(pat[767-i]);
            if (i == 766) begin
                chk("cnt_767", 32'(bit_count), 32'd767);
                chk("done_early", 32'(cap_done), 32'd0);
            end
        end
        chk("full_done", 32'(cap_done), 32'd1);
        chk("full_busy", 32'(cap_busy), 32'd0);
        chk("full_count", 32'(bit_count), 32'd768);
        for (int v = 0; v < 6; v++) begin
            do_read(vec[v].addr, d, e, k);
            chk("vec_ack", 32'(k), 32'd1);
            chk("vec_data", d, vec[v].exp_data);
            chk("vec_err", 32'(e), 32'(vec[v].exp_err));
        end
        tick();
        chk("ack_one_cycle", 32'(rd_if.rd_ack), 32'd0);

        // Back-to-back reads at full rate
        rd_if.rd_req = 1'b1;
        for (int w = 0; w < 24; w++) begin
            rd_if.rd_addr = 5'(w);
            tick();
            chk("b2b_ack", 32'(rd_if.rd_ack), 32'd1);
            chk("b2b_data", rd_if.rd_data, pat[w*32 +: 32]);
        end
        rd_if.rd_req = 1'b0;
        tick();
        chk("b2b_ack_end", 32'(rd_if.rd_ack), 32'd0);

        // Overflow after DONE
        strobe(1'b1);
        strobe(1'b0);
        chk("ovf_set", 32'(cap_overflow), 32'd1);
        chk("ovf_done", 32'(cap_done), 32'd1);
        chk("ovf_count", 32'(bit_count), 32'd768);
        do_read(5'd0, d, e, k);
        chk("ovf_word0", d, pat[31:0]);

        // Restart with skip=3
        start(6'd3);
        chk("restart_ovf", 32'(cap_overflow), 32'd0);
        chk("restart_count", 32'(bit_count), 32'd0);
        chk("restart_busy", 32'(cap_busy), 32'd1);
        for (int i = 0; i < 3; i++) strobe(1'b1);
        chk("skip_count", 32'(bit_count), 32'd0);
        do_read(5'd5, d, e, k);
        chk("busy_rd_err", 32'(e), 32'd1);
        chk("busy_rd_ack", 32'(k), 32'd1);
        for (int i = 0; i < 767; i++) strobe(1'b0);
        chk("skip_not_done", 32'(cap_done), 32'd0);
        strobe(1'b0);
        chk("skip_done_771", 32'(cap_done), 32'd1);
        read_all(acc, eacc);
        chk("skip_words", acc, 32'd0);

        // Pause via shift_en
        start(6'd0);
        for (int i = 0; i < 100; i++) strobe(1'b1);
        shift_en = 1'b0;
        for (int i = 0; i < 50; i++) strobe(1'b0);
        chk("pause_count", 32'(bit_count), 32'd100);
        chk("pause_busy", 32'(cap_busy), 32'd1);
        do_read(5'd0, d, e, k);
        chk("partial_word0", d, 32'hFFFF_FFFF);
        chk("partial_err", 32'(e), 32'd1);
        shift_en = 1'b1;

        // Read coincident with a strobe sees pre-shift storage
        rd_if.rd_req  = 1'b1;
        rd_if.rd_addr = 5'd3;
        sample_stb    = 1'b1;
        scan_out      = 1'b1;
        tick();
        rd_if.rd_req = 1'b0;
        sample_stb   = 1'b0;
        scan_out     = 1'b0;
        chk("coinc_data", rd_if.rd_data, 32'h0000_000F);
        chk("coinc_count", 32'(bit_count), 32'd101);

        // cap_start with a strobe in the same cycle
        cfg_skip   = 6'd0;
        cap_start  = 1'b1;
        sample_stb = 1'b1;
        scan_out   = 1'b1;
        tick();
        cap_start  = 1'b0;
        sample_stb = 1'b0;
        scan_out   = 1'b0;
        chk("simul_count", 32'(bit_count), 32'd0);
        chk("simul_busy", 32'(cap_busy), 32'd1);
        do_read(5'd0, d, e, k);
        chk("simul_word0", d, 32'd0);

        // Reset wins over cap_start
        fw_rst    = 1'b1;
        cap_start = 1'b1;
        cfg_skip  = 6'd2;
        tick();
        fw_rst    = 1'b0;
        cap_start = 1'b0;
        chk("rst_prio_busy", 32'(cap_busy), 32'd0);
        chk("rst_prio_done", 32'(cap_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
